// File: rtl/phy_rx_sync_ctrl.sv
// -----------------------------------------------------------------------------
// phy_rx_sync_ctrl
// Lane-alignment and lock controller for the two-lane serial receive path.
// Each lane shifts its serial bit stream (MSB first) and hunts for COM_SYM to
// fix the byte boundary. After COM_COUNT consecutive aligned COMs the lane is
// locked; locked lanes emit aligned bytes and a strobe for every non-COM byte.
// Lanes are independent; no skew compensation is done.
//
// Ports
//   clk_8f         in   bit-rate clock, all logic on posedge
//   reset          in   asynchronous active-high reset
//   enable         in   synchronous enable; low forces both lanes to SEARCH
//   in_0 / in_1    in   serial data per lane, MSB first
//   align_byte_x   out  last completed aligned byte (held between strobes)
//   align_valid_x  out  one-cycle strobe: locked and completed byte != COM_SYM
//   lock_x         out  lane x in LOCKED
//   active         out  registered lock_0 & lock_1
//
// Optional feature: define SYNC_LOSS_EN to add per-lane loss-of-lock
// detection (LOSS_WINDOW consecutive non-COM locked bytes drop the lock).
// Without it LOCKED is left only through enable low or reset.
//
// state  | meaning
// SEARCH | bitwise hunt for COM_SYM
// ALIGN  | boundary fixed, counting consecutive aligned COMs
// LOCKED | lane locked, delivering aligned bytes
// -----------------------------------------------------------------------------
module phy_rx_sync_ctrl #(
  parameter logic [7:0] COM_SYM     = 8'hBC,
  parameter int         COM_COUNT   = 4
`ifdef SYNC_LOSS_EN
  ,
  parameter int         LOSS_WINDOW = 16
`endif
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_0,
  input  logic       in_1,
  output logic [7:0] align_byte_0,
  output logic [7:0] align_byte_1,
  output logic       align_valid_0,
  output logic       align_valid_1,
  output logic       lock_0,
  output logic       lock_1,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    ALIGN  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [3:0] COM_NEED = 4'(COM_COUNT);

  logic [1:0] ser;
  assign ser = {in_1, in_0};

  state_t     state     [2];
  state_t     state_nxt [2];
  // Only the 7 newest bits are needed: the incoming bit completes the byte.
  logic [6:0] sh        [2];
  logic [7:0] shift     [2];
  logic [2:0] bcnt      [2];
  logic [2:0] bcnt_nxt  [2];
  logic [3:0] ccnt      [2];
  logic [3:0] ccnt_nxt  [2];
  logic [7:0] byte_q    [2];
  logic [7:0] byte_nxt  [2];
  logic [1:0] valid_q;
  logic [1:0] valid_nxt;
  logic       active_q;

`ifdef SYNC_LOSS_EN
  localparam logic [7:0] LOSS_LIM = 8'(LOSS_WINDOW);
  logic [7:0] miss     [2];
  logic [7:0] miss_nxt [2];
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      shift[i]     = {sh[i], ser[i]};
      state_nxt[i] = state[i];
      bcnt_nxt[i]  = bcnt[i];
      ccnt_nxt[i]  = ccnt[i];
      byte_nxt[i]  = byte_q[i];
      valid_nxt[i] = 1'b0;
`ifdef SYNC_LOSS_EN
      miss_nxt[i]  = miss[i];
`endif
      if (!enable) begin
        state_nxt[i] = SEARCH;
        bcnt_nxt[i]  = 3'd0;
        ccnt_nxt[i]  = 4'd0;
`ifdef SYNC_LOSS_EN
        miss_nxt[i]  = 8'd0;
`endif
      end else begin
        case (state[i])
          SEARCH: begin
            bcnt_nxt[i] = 3'd0;
            if (shift[i] == COM_SYM) begin
              ccnt_nxt[i]  = 4'd1;
              state_nxt[i] = (COM_NEED == 4'd1) ? LOCKED : ALIGN;
            end
          end
          ALIGN: begin
            bcnt_nxt[i] = bcnt[i] + 3'd1;
            if (bcnt[i] == 3'd7) begin
              if (shift[i] == COM_SYM) begin
                ccnt_nxt[i] = ccnt[i] + 4'd1;
                if (ccnt[i] + 4'd1 == COM_NEED) state_nxt[i] = LOCKED;
              end else begin
                // No slip memory: hunting restarts on the very next bit.
                state_nxt[i] = SEARCH;
                ccnt_nxt[i]  = 4'd0;
              end
            end
          end
          LOCKED: begin
            bcnt_nxt[i] = bcnt[i] + 3'd1;
            if (bcnt[i] == 3'd7) begin
              byte_nxt[i] = shift[i];
`ifdef SYNC_LOSS_EN
              if (shift[i] == COM_SYM) begin
                miss_nxt[i] = 8'd0;
              end else if (miss[i] + 8'd1 == LOSS_LIM) begin
                // The byte that exhausts the window is not strobed.
                state_nxt[i] = SEARCH;
                ccnt_nxt[i]  = 4'd0;
                miss_nxt[i]  = 8'd0;
              end else begin
                miss_nxt[i]  = miss[i] + 8'd1;
                valid_nxt[i] = 1'b1;
              end
`else
              valid_nxt[i] = (shift[i] != COM_SYM);
`endif
            end
          end
          default: begin
            state_nxt[i] = SEARCH;
            bcnt_nxt[i]  = 3'd0;
            ccnt_nxt[i]  = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state[i]  <= SEARCH;
        sh[i]     <= 7'd0;
        bcnt[i]   <= 3'd0;
        ccnt[i]   <= 4'd0;
        byte_q[i] <= 8'd0;
`ifdef SYNC_LOSS_EN
        miss[i]   <= 8'd0;
`endif
      end
      valid_q  <= 2'b00;
      active_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i]  <= state_nxt[i];
        bcnt[i]   <= bcnt_nxt[i];
        ccnt[i]   <= ccnt_nxt[i];
        byte_q[i] <= byte_nxt[i];
        if (enable) sh[i] <= shift[i][6:0];
`ifdef SYNC_LOSS_EN
        miss[i]   <= miss_nxt[i];
`endif
      end
      valid_q  <= valid_nxt;
      active_q <= enable && (state[0] == LOCKED) && (state[1] == LOCKED);
    end
  end

  assign align_byte_0  = byte_q[0];
  assign align_byte_1  = byte_q[1];
  assign align_valid_0 = valid_q[0];
  assign align_valid_1 = valid_q[1];
  assign lock_0        = (state[0] == LOCKED);
  assign lock_1        = (state[1] == LOCKED);
  assign active        = active_q;

endmodule
